// File: rtl/control_pkg.sv
// Shared encodings for the registered ID/EX control decoder: opcodes, functs,
// ALUOp/branch/regDst codes, the control bundle layout and the pipe FSM states.
`default_nettype none

package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LOAD  = 6'b100???;
  localparam logic [5:0] OP_STORE = 6'b101???;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_JR = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RFUNC = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_XOR   = 3'b101;
  localparam logic [2:0] ALU_LUI   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_BEQ  = 3'b001;
  localparam logic [2:0] BR_BNE  = 3'b010;
  localparam logic [2:0] BR_JMP  = 3'b011;
  localparam logic [2:0] BR_JR   = 3'b100;

  localparam logic [1:0] DST_RT  = 2'b00;
  localparam logic [1:0] DST_RD  = 2'b01;
  localparam logic [1:0] DST_R31 = 2'b10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [2:0] branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // R-type functs the EX-stage ALU understands; anything else is flagged illegal.
  function automatic logic funct_legal(input logic [5:0] funct);
    case (funct)
      6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
      6'b001000, 6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
      6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011:
        funct_legal = 1'b1;
      default:
        funct_legal = 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// Purely combinational decode of one instruction word into the control bundle,
// plus halt / illegal / nop classification for the pipe register stage.
`default_nettype none

module control_decode
  import control_pkg::*;
#(
  parameter int N_BITS      = 32,
  parameter int N_BITS_OP   = 6,
  parameter int N_BITS_FUNC = 6
) (
  input  logic [N_BITS-1:0] instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic              is_halt,
  output logic              is_illegal,
  output logic              is_nop
);

  logic [N_BITS_OP-1:0]   opcode;
  logic [N_BITS_FUNC-1:0] funct;
  ctrl_t                  dec;
  logic                   halt_raw;
  logic                   illegal_raw;

  assign opcode = instr[N_BITS-1 -: N_BITS_OP];
  assign funct  = instr[N_BITS_FUNC-1:0];
  assign is_nop = (instr == '0);

  always_comb begin
    dec         = '0;
    halt_raw    = 1'b0;
    illegal_raw = 1'b0;
    casez (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = DST_RD;
        dec.alu_op    = ALU_RFUNC;
        dec.reg_write = 1'b1;
        if (funct == FN_JR) begin
          dec.branch    = BR_JR;
          dec.reg_write = 1'b0;
        end else if (!funct_legal(funct)) begin
          illegal_raw = 1'b1;
        end
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dst   = DST_RT;
        case (opcode)
          OP_SLTI: dec.alu_op = ALU_SLT;
          OP_ANDI: dec.alu_op = ALU_AND;
          OP_ORI:  dec.alu_op = ALU_OR;
          OP_XORI: dec.alu_op = ALU_XOR;
          OP_LUI:  dec.alu_op = ALU_LUI;
          default: dec.alu_op = ALU_ADD;
        endcase
      end
      OP_BEQ: begin
        dec.branch = BR_BEQ;
        dec.alu_op = ALU_SUB;
      end
      OP_BNE: begin
        dec.branch = BR_BNE;
        dec.alu_op = ALU_SUB;
      end
      OP_J: dec.branch = BR_JMP;
      OP_JAL: begin
        dec.branch    = BR_JMP;
        dec.reg_dst   = DST_R31;
        dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_op     = ALU_ADD;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_ADD;
      end
      OP_HALT: halt_raw = 1'b1;
      default: illegal_raw = 1'b1;
    endcase
  end

  // The all-zero word decodes as an R-type sll; it must stay a silent nop.
  assign is_halt    = halt_raw && !is_nop;
  assign is_illegal = illegal_raw && !is_nop;
  assign ctrl       = (is_nop || halt_raw || illegal_raw) ? '0 : dec;

endmodule

`default_nettype wire

// File: rtl/control_pipe.sv
// ID/EX control register with stall/flush bubbles, halt-drain FSM,
// illegal-opcode pulse and a count of issued valid control words.
`default_nettype none

module control_pipe
  import control_pkg::*;
#(
  parameter int N_BITS       = 32,
  parameter int N_BITS_OP    = 6,
  parameter int N_BITS_FUNC  = 6,
  parameter int N_BITS_ALUOP = 3,
  parameter int DRAIN_CYCLES = 4,
  parameter int N_BITS_CNT   = N_BITS
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_stall,
  input  logic                    i_flush,
  input  logic [N_BITS-1:0]       i_instruccion,
  output logic [N_BITS_ALUOP-1:0] o_control_EX_ALUOp,
  output logic                    o_control_EX_ALUSrc,
  output logic [1:0]              o_control_EX_regDst,
  output logic [2:0]              o_control_M_branch,
  output logic                    o_control_M_memRead,
  output logic                    o_control_M_memWrite,
  output logic                    o_control_WB_memtoReg,
  output logic                    o_control_WB_regWrite,
  output logic                    o_ctrl_valid,
  output logic                    o_illegal,
  output logic                    o_draining,
  output logic                    o_halted,
  output logic [N_BITS_CNT-1:0]   o_instr_count
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  logic [CTRL_W-1:0] dec_bits;
  ctrl_t             dec_ctrl;
  logic              dec_halt;
  logic              dec_illegal;
  logic              dec_nop;

  state_t            state;
  state_t            state_next;
  logic [DRAIN_W-1:0] drain_cnt;

  logic              accept;
  logic              take_halt;
  logic              issue_valid;
  logic              illegal_next;
  ctrl_t             issue_ctrl;

  ctrl_t             ctrl_q;
  logic              valid_q;
  logic              illegal_q;
  logic [N_BITS_CNT-1:0] count_q;

  control_decode #(
    .N_BITS      (N_BITS),
    .N_BITS_OP   (N_BITS_OP),
    .N_BITS_FUNC (N_BITS_FUNC)
  ) u_decode (
    .instr      (i_instruccion),
    .ctrl       (dec_bits),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal),
    .is_nop     (dec_nop)
  );

  assign dec_ctrl = ctrl_t'(dec_bits);

  // Decode only reaches the register when nothing of higher priority intervenes.
  assign accept    = (state == ST_RUN) && !i_flush && !i_stall && i_valid;
  assign take_halt = accept && dec_halt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:    if (take_halt) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt == '0) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  always_comb begin
    issue_valid  = 1'b0;
    illegal_next = 1'b0;
    issue_ctrl   = '0;
    if (accept) begin
      illegal_next = dec_illegal;
      if (!dec_nop && !dec_halt && !dec_illegal) begin
        issue_valid = 1'b1;
        issue_ctrl  = dec_ctrl;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      drain_cnt <= '0;
    end else if (take_halt) begin
      drain_cnt <= DRAIN_W'(DRAIN_CYCLES - 1);
    end else if (state == ST_DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      ctrl_q    <= issue_ctrl;
      valid_q   <= issue_valid;
      illegal_q <= illegal_next;
      if (issue_valid) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign o_control_EX_ALUOp    = N_BITS_ALUOP'(ctrl_q.alu_op);
  assign o_control_EX_ALUSrc   = ctrl_q.alu_src;
  assign o_control_EX_regDst   = ctrl_q.reg_dst;
  assign o_control_M_branch    = ctrl_q.branch;
  assign o_control_M_memRead   = ctrl_q.mem_read;
  assign o_control_M_memWrite  = ctrl_q.mem_write;
  assign o_control_WB_memtoReg = ctrl_q.mem_to_reg;
  assign o_control_WB_regWrite = ctrl_q.reg_write;
  assign o_ctrl_valid          = valid_q;
  assign o_illegal             = illegal_q;
  assign o_draining            = (state == ST_DRAIN);
  assign o_halted              = (state == ST_HALTED);
  assign o_instr_count         = count_q;

endmodule

`default_nettype wire

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: decode table, stall/flush, illegal, halt drain,
// asynchronous reset mid-drain and counter wrap on a 4-bit-counter instance.
`default_nettype none

module tb_control_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, stall, flush;
  logic [31:0] instr;

  logic [2:0]  alu_op, alu_op4;
  logic        alu_src, alu_src4;
  logic [1:0]  reg_dst, reg_dst4;
  logic [2:0]  branch, branch4;
  logic        mem_read, mem_read4, mem_write, mem_write4;
  logic        mem_to_reg, mem_to_reg4, reg_write, reg_write4;
  logic        ctrl_valid, ctrl_valid4, illegal, illegal4;
  logic        draining, draining4, halted, halted4;
  logic [31:0] count;
  logic [3:0]  count4;

  int vecs  = 0;
  int fails = 0;

  localparam logic [31:0] I_ADD  = 32'h012A4020;
  localparam logic [31:0] I_LW   = 32'h8D090004;
  localparam logic [31:0] I_SW   = 32'hAD090004;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_ILL  = 32'hF8000000;
  localparam logic [31:0] I_HALT = 32'hFC000000;

  always #5 clk = ~clk;

  control_pipe dut (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_instruccion(instr),
    .o_control_EX_ALUOp(alu_op), .o_control_EX_ALUSrc(alu_src), .o_control_EX_regDst(reg_dst),
    .o_control_M_branch(branch), .o_control_M_memRead(mem_read), .o_control_M_memWrite(mem_write),
    .o_control_WB_memtoReg(mem_to_reg), .o_control_WB_regWrite(reg_write),
    .o_ctrl_valid(ctrl_valid), .o_illegal(illegal), .o_draining(draining), .o_halted(halted),
    .o_instr_count(count)
  );

  control_pipe #(.N_BITS_CNT(4)) dut4 (
    .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_instruccion(instr),
    .o_control_EX_ALUOp(alu_op4), .o_control_EX_ALUSrc(alu_src4), .o_control_EX_regDst(reg_dst4),
    .o_control_M_branch(branch4), .o_control_M_memRead(mem_read4), .o_control_M_memWrite(mem_write4),
    .o_control_WB_memtoReg(mem_to_reg4), .o_control_WB_regWrite(reg_write4),
    .o_ctrl_valid(ctrl_valid4), .o_illegal(illegal4), .o_draining(draining4), .o_halted(halted4),
    .o_instr_count(count4)
  );

  // Expected word layout: {ALUOp, ALUSrc, regDst, branch, memRead, memWrite, memtoReg, regWrite, valid}
  function automatic logic [13:0] mk(input logic [2:0] a, input logic s, input logic [1:0] d,
                                     input logic [2:0] b, input logic mr, input logic mw,
                                     input logic m2r, input logic rw, input logic v);
    mk = {a, s, d, b, mr, mw, m2r, rw, v};
  endfunction

  function automatic logic [13:0] word();
    word = {alu_op, alu_src, reg_dst, branch, mem_read, mem_write, mem_to_reg, reg_write, ctrl_valid};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic s, input logic f, input logic [31:0] i);
    valid = v; stall = s; flush = f; instr = i;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0; stall = 1'b0; flush = 1'b0; instr = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_word", 32'(word()), 32'h0);
    chk("reset_count", count, 0);
    chk("reset_status", {29'b0, illegal, draining, halted}, 0);
    rst = 1'b0;

    step(1, 0, 0, I_ADD);
    chk("add", 32'(word()), 32'(mk(3'b010, 0, 2'b01, 3'b000, 0, 0, 0, 1, 1)));
    step(1, 0, 0, I_LW);
    chk("lw", 32'(word()), 32'(mk(3'b000, 1, 2'b00, 3'b000, 1, 0, 1, 1, 1)));
    step(1, 0, 0, I_SW);
    chk("sw", 32'(word()), 32'(mk(3'b000, 1, 2'b00, 3'b000, 0, 1, 0, 0, 1)));
    step(1, 0, 0, I_BEQ);
    chk("beq", 32'(word()), 32'(mk(3'b001, 0, 2'b00, 3'b001, 0, 0, 0, 0, 1)));
    step(1, 0, 0, I_JAL);
    chk("jal", 32'(word()), 32'(mk(3'b000, 0, 2'b10, 3'b011, 0, 0, 0, 1, 1)));
    chk("count_after_5", count, 5);

    step(1, 1, 0, I_LW);
    chk("stall_bubble", 32'(word()), 32'h0);
    chk("stall_count", count, 5);
    step(1, 0, 0, I_LW);
    chk("lw_after_stall", 32'(word()), 32'(mk(3'b000, 1, 2'b00, 3'b000, 1, 0, 1, 1, 1)));
    step(1, 0, 1, I_BEQ);
    chk("flush_bubble", 32'(word()), 32'h0);
    chk("flush_count", count, 6);
    step(0, 0, 0, I_ADD);
    chk("invalid_bubble", 32'(word()), 32'h0);
    step(1, 0, 0, 32'h0);
    chk("nop_bubble", 32'(word()), 32'h0);
    chk("nop_not_illegal", 32'(illegal), 0);
    chk("nop_count", count, 6);

    step(1, 0, 0, I_ILL);
    chk("illegal_bubble", 32'(word()), 32'h0);
    chk("illegal_pulse", 32'(illegal), 1);
    step(1, 0, 0, I_ADD);
    chk("illegal_drop", 32'(illegal), 0);
    chk("add_after_illegal", 32'(word()), 32'(mk(3'b010, 0, 2'b01, 3'b000, 0, 0, 0, 1, 1)));
    chk("count_after_illegal", count, 7);

    step(1, 0, 1, I_HALT);
    chk("halt_flushed_bubble", 32'(word()), 32'h0);
    chk("halt_flushed_run", {30'b0, draining, halted}, 0);
    step(1, 0, 0, I_ADD);
    chk("add_after_flushed_halt", 32'(word()), 32'(mk(3'b010, 0, 2'b01, 3'b000, 0, 0, 0, 1, 1)));
    chk("count_8", count, 8);

    step(1, 0, 0, I_HALT);
    chk("halt_bubble", 32'(word()), 32'h0);
    chk("drain_1", {30'b0, draining, halted}, 2);
    for (int k = 2; k <= 4; k++) begin
      step(1, 0, 0, I_ADD);
      chk($sformatf("drain_%0d", k), {30'b0, draining, halted}, 2);
      chk($sformatf("drain_word_%0d", k), 32'(word()), 32'h0);
    end
    step(1, 0, 0, I_ADD);
    chk("halted", {30'b0, draining, halted}, 1);
    step(1, 0, 0, I_ADD);
    chk("halted_word", 32'(word()), 32'h0);
    chk("halted_sticky", 32'(halted), 1);
    chk("halted_count_frozen", count, 8);

    do_reset();
    chk("reset_clears_halted", {30'b0, draining, halted}, 0);
    step(1, 0, 0, I_HALT);
    step(1, 0, 0, I_ADD);
    chk("drain_before_reset", 32'(draining), 1);
    rst = 1'b1;
    #2;
    chk("async_reset_word", 32'(word()), 32'h0);
    chk("async_reset_status", {29'b0, illegal, draining, halted}, 0);
    chk("async_reset_count", count, 0);
    rst = 1'b0;
    step(1, 0, 0, I_ADD);
    chk("add_after_reset", 32'(word()), 32'(mk(3'b010, 0, 2'b01, 3'b000, 0, 0, 0, 1, 1)));
    chk("count_after_reset", count, 1);

    do_reset();
    for (int k = 0; k < 15; k++) step(1, 0, 0, I_ADD);
    chk("count4_at_15", 32'(count4), 15);
    step(1, 0, 0, I_ADD);
    chk("count4_wrap", 32'(count4), 0);
    chk("count32_at_16", count, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

`default_nettype wire
